// File: rtl/response_control_if.sv
// rtl/response_control_if.sv - PSL response, tag pool, credit and decoded-response signals
interface response_control_if #(
  parameter int ID_W = 8
);
  // block control and credit path
  logic              enabled;
  logic              command_issued;
  logic [8:0]        credits;
  logic              credit_ready;

  // PSL response bus
  logic              ha_rvalid;
  logic [7:0]        ha_rtag;
  logic [7:0]        ha_response;
  logic [8:0]        ha_rcredits;

  // tag RAM lookup and tag return
  logic [7:0]        lookup_tag;
  logic [ID_W-1:0]   lookup_id;
  logic              tag_return_valid;
  logic [7:0]        tag_return;

  // decoded response queue head
  logic              rsp_out_valid;
  logic              rsp_out_ready;
  logic [ID_W-1:0]   rsp_out_id;
  logic [7:0]        rsp_out_code;

  // sticky error reporting
  logic              error_valid;
  logic [7:0]        error_code;
  logic              error_overflow;
  logic              error_credit;

  // the response control block itself
  modport slave (
    input  enabled, command_issued, ha_rvalid, ha_rtag, ha_response, ha_rcredits,
    input  lookup_id, rsp_out_ready,
    output credits, credit_ready, lookup_tag, tag_return_valid, tag_return,
    output rsp_out_valid, rsp_out_id, rsp_out_code,
    output error_valid, error_code, error_overflow, error_credit
  );

  // the surrounding PSL / tag pool / arbiter environment
  modport master (
    output enabled, command_issued, ha_rvalid, ha_rtag, ha_response, ha_rcredits,
    output lookup_id, rsp_out_ready,
    input  credits, credit_ready, lookup_tag, tag_return_valid, tag_return,
    input  rsp_out_valid, rsp_out_id, rsp_out_code,
    input  error_valid, error_code, error_overflow, error_credit
  );
endinterface

// File: rtl/response_control.sv
// rtl/response_control.sv - PSL response receive path: tag return, CU lookup, response queue, credits
module response_control #(
  parameter int CREDITS_INIT   = 64,
  parameter int CREDITS_MAX    = 255,
  parameter int RSP_FIFO_DEPTH = 32,
  // width of a CommandTagLine {cu_id, cmd_type}; must match the interface ID_W
  parameter int ID_W           = 8
) (
  input  logic              clock,
  input  logic              rst,
  response_control_if.slave bus
);

  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0] RSP_DONE  = 8'h00;
  localparam logic [7:0] RSP_PAGED = 8'h0A;

  localparam logic signed [10:0] CREDIT_MAX_S = 11'(CREDITS_MAX);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1
  } state_t;

  state_t state;
  logic   run;

  logic             s1_valid;
  logic [7:0]       s1_tag;
  logic [7:0]       s1_code;
  logic [8:0]       s1_credits;

  logic             s2_valid;
  logic [7:0]       s2_code;
  logic [ID_W-1:0]  s2_id;

  logic [ID_W-1:0]  mem_id   [RSP_FIFO_DEPTH];
  logic [7:0]       mem_code [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             push_ok;

  logic [8:0]         credits_q;
  logic signed [10:0] credit_sum;
  logic               credit_under;
  logic               credit_over;

  logic             error_valid_q;
  logic [7:0]       error_code_q;
  logic             error_overflow_q;
  logic             error_credit_q;

  // Responses are only accepted in ST_RUN; dropping enabled flushes on the next edge.
  assign run = (state == ST_RUN) && bus.enabled;

  // Control FSM: ST_RESET until the first enabled clock, back to ST_RESET whenever disabled.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= ST_RESET;
    end else if (!bus.enabled) begin
      state <= ST_RESET;
    end else begin
      state <= ST_RUN;
    end
  end

  // Stage 1: register the raw PSL response; the tag drives both the RAM lookup and the tag return.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_tag     <= 8'h00;
      s1_code    <= 8'h00;
      s1_credits <= 9'h000;
    end else begin
      s1_valid   <= run && bus.ha_rvalid;
      s1_tag     <= bus.ha_rtag;
      s1_code    <= bus.ha_response;
      s1_credits <= bus.ha_rcredits;
    end
  end

  assign bus.lookup_tag       = s1_tag;
  assign bus.tag_return       = s1_tag;
  // Gated by enabled so a response caught in S1 when the block is disabled never frees its tag.
  assign bus.tag_return_valid = s1_valid && bus.enabled;

  // Stage 2: capture the tag RAM read data together with the code, before the tag can be reissued.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_code  <= 8'h00;
      s2_id    <= '0;
    end else begin
      s2_valid <= run && s1_valid;
      s2_code  <= s1_code;
      s2_id    <= bus.lookup_id;
    end
  end

  assign fifo_full = (count == CNT_W'(RSP_FIFO_DEPTH));
  assign pop       = bus.rsp_out_valid && bus.rsp_out_ready;
  assign push      = s2_valid;
  // A push into a full queue still fits when the head leaves in the same cycle.
  assign push_ok   = push && (!fifo_full || pop);

  // Queue storage: no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (run && push_ok) begin
      mem_id[wr_ptr]   <= s2_id;
      mem_code[wr_ptr] <= s2_code;
    end
  end

  // Queue pointers and occupancy; the flush on disable empties it.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!run) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  assign bus.rsp_out_valid = (count != '0);
  assign bus.rsp_out_id    = mem_id[rd_ptr];
  assign bus.rsp_out_code  = mem_code[rd_ptr];

  // Credit arithmetic in 11-bit signed so both clamp directions are visible.
  always_comb begin
    credit_sum = $signed({2'b00, credits_q});
    if (s1_valid) begin
      credit_sum = credit_sum + $signed({{2{s1_credits[8]}}, s1_credits});
    end
    if (bus.command_issued) begin
      credit_sum = credit_sum - 11'sd1;
    end
    credit_under = (credit_sum < 11'sd0);
    credit_over  = (credit_sum > CREDIT_MAX_S);
  end

  // Credit counter with clamping; reloads whenever the block is not running.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      credits_q      <= 9'(CREDITS_INIT);
      error_credit_q <= 1'b0;
    end else if (!run) begin
      credits_q      <= 9'(CREDITS_INIT);
      error_credit_q <= 1'b0;
    end else begin
      if (credit_under) begin
        credits_q      <= 9'h000;
        error_credit_q <= 1'b1;
      end else if (credit_over) begin
        credits_q      <= 9'(CREDITS_MAX);
        error_credit_q <= 1'b1;
      end else begin
        credits_q <= credit_sum[8:0];
      end
    end
  end

  assign bus.credits      = credits_q;
  assign bus.credit_ready = (credits_q != 9'h000);

  // Sticky error capture: the first non-DONE, non-PAGED code wins; overflow on a dropped push.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      error_valid_q    <= 1'b0;
      error_code_q     <= 8'h00;
      error_overflow_q <= 1'b0;
    end else if (!run) begin
      error_valid_q    <= 1'b0;
      error_code_q     <= 8'h00;
      error_overflow_q <= 1'b0;
    end else begin
      if (s2_valid && (s2_code != RSP_DONE) && (s2_code != RSP_PAGED) && !error_valid_q) begin
        error_valid_q <= 1'b1;
        error_code_q  <= s2_code;
      end
      if (push && !push_ok) begin
        error_overflow_q <= 1'b1;
      end
    end
  end

  assign bus.error_valid    = error_valid_q;
  assign bus.error_code     = error_code_q;
  assign bus.error_overflow = error_overflow_q;
  assign bus.error_credit   = error_credit_q;

endmodule
